// File: rtl/bin_act_accum_if.sv
// -----------------------------------------------------------------------------
// bin_act_accum_if
//
// Purpose:
//   Groups the two streaming handshakes of bin_act_accum into one bundle:
//   the partial-sum input stream coming from the binary dot-product stage and
//   the activation/sum result stream going to the next binary layer.
//
// Signals:
//   in_valid   beat valid from upstream
//   in_ready   accumulator can take a beat
//   value_in   OUTPUT_DIM lanes of signed BIT_CNT partial sums
//   threshold  OUTPUT_DIM lanes of signed ACC_W folded-batchnorm thresholds
//   thr_inv    per-lane comparison inversion (only with BIN_ACT_INV_EN)
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   act_out    binary activation vector (1 = +1, 0 = -1)
//   sum_out    accumulated sums saturated to BIT_CNT
//
// Modports:
//   slave   the accumulator side
//   master  the environment side (upstream producer plus downstream consumer)
//
// Optional feature macro: BIN_ACT_INV_EN adds thr_inv.
// -----------------------------------------------------------------------------
interface bin_act_accum_if #(
    parameter int OUTPUT_DIM  = 16,
    parameter int BIT_CNT     = 8,
    parameter int CHANNEL_CNT = 4
);
    localparam int ACC_W = BIT_CNT + $clog2(CHANNEL_CNT) + 1;

    logic                                 in_valid;
    logic                                 in_ready;
    logic [OUTPUT_DIM-1:0][BIT_CNT-1:0]   value_in;
    logic [OUTPUT_DIM-1:0][ACC_W-1:0]     threshold;
`ifdef BIN_ACT_INV_EN
    logic [OUTPUT_DIM-1:0]                thr_inv;
`endif
    logic                                 out_valid;
    logic                                 out_ready;
    logic [OUTPUT_DIM-1:0]                act_out;
    logic [OUTPUT_DIM-1:0][BIT_CNT-1:0]   sum_out;

    modport slave (
        input  in_valid, value_in, threshold, out_ready,
`ifdef BIN_ACT_INV_EN
        input  thr_inv,
`endif
        output in_ready, out_valid, act_out, sum_out
    );

    modport master (
        output in_valid, value_in, threshold, out_ready,
`ifdef BIN_ACT_INV_EN
        output thr_inv,
`endif
        input  in_ready, out_valid, act_out, sum_out
    );

endinterface

// File: rtl/bin_act_accum.sv
// -----------------------------------------------------------------------------
// bin_act_accum
//
// Purpose:
//   Accumulates CHANNEL_CNT beats of OUTPUT_DIM signed partial sums (one beat
//   per input channel group), then compares each lane's total against a
//   folded-batchnorm threshold to produce a binary activation vector. The
//   total is also reported saturated back to BIT_CNT bits.
//
// Ports:
//   clk     clock
//   rst_n   asynchronous active-low reset
//   flush   synchronous discard of the partial group (ignored while a result
//           is pending)
//   ch_cnt  beats accepted in the current group; reads CHANNEL_CNT while the
//           result is held
//   bus     bin_act_accum_if.slave: input beat stream and result stream
//
// Optional feature macro: BIN_ACT_INV_EN
//   When defined, bus.thr_inv selects per lane a "<=" comparison instead of
//   ">=", which folds a negative batchnorm gamma into the threshold.
//   When undefined, every lane uses ">=".
// -----------------------------------------------------------------------------
module bin_act_accum #(
    parameter int OUTPUT_DIM  = 16,
    parameter int BIT_CNT     = 8,
    parameter int CHANNEL_CNT = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               flush,
    output logic [$clog2(CHANNEL_CNT):0]       ch_cnt,
    bin_act_accum_if.slave                     bus
);

    localparam int ACC_W = BIT_CNT + $clog2(CHANNEL_CNT) + 1;
    localparam int CNT_W = $clog2(CHANNEL_CNT) + 1;

    // Saturation bounds expressed at accumulator width. The lower bound is
    // the bitwise complement of the upper one: 0..0111..1 -> 1..1000..0.
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (BIT_CNT - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHANNEL_CNT - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CHANNEL_CNT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                              state_q, state_d;
    logic [CNT_W-1:0]                    ch_cnt_q, ch_cnt_d;
    logic signed [ACC_W-1:0]             acc_q [OUTPUT_DIM];
    logic signed [ACC_W-1:0]             acc_d [OUTPUT_DIM];
    logic [OUTPUT_DIM-1:0]               act_q, act_d;
    logic [OUTPUT_DIM-1:0][BIT_CNT-1:0]  sum_q, sum_d;

    logic                                accept;
    logic                                last_beat;
    logic signed [ACC_W-1:0]             lane_ext [OUTPUT_DIM];
    logic signed [ACC_W-1:0]             lane_sum [OUTPUT_DIM];
    logic [OUTPUT_DIM-1:0]               lane_act;
    logic [OUTPUT_DIM-1:0][BIT_CNT-1:0]  lane_sat;

    // Input side is only blocked while a finished result waits to drain, so
    // no beat can be taken in the same cycle as the output handshake.
    assign bus.in_ready  = (state_q != HOLD);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.act_out   = act_q;
    assign bus.sum_out   = sum_q;
    assign ch_cnt        = ch_cnt_q;

    assign accept    = bus.in_valid && bus.in_ready;
    assign last_beat = (ch_cnt_q == LAST_CNT);

    // Per-lane datapath, evaluated every cycle from the current beat. When a
    // group is just starting (ch_cnt 0) the stale accumulator is ignored, so
    // the same running sum serves both as the next accumulator value and, on
    // the last beat, as the final total fed to the threshold and saturator.
    always_comb begin
        lane_act = '0;
        lane_sat = '0;
        for (int i = 0; i < OUTPUT_DIM; i++) begin
            lane_ext[i] = {{(ACC_W - BIT_CNT){bus.value_in[i][BIT_CNT-1]}}, bus.value_in[i]};
            lane_sum[i] = ((ch_cnt_q == '0) ? '0 : acc_q[i]) + lane_ext[i];

`ifdef BIN_ACT_INV_EN
            if (bus.thr_inv[i]) begin
                lane_act[i] = (lane_sum[i] <= $signed(bus.threshold[i]));
            end else begin
                lane_act[i] = (lane_sum[i] >= $signed(bus.threshold[i]));
            end
`else
            lane_act[i] = (lane_sum[i] >= $signed(bus.threshold[i]));
`endif

            if (lane_sum[i] > SAT_MAX) begin
                lane_sat[i] = SAT_MAX[BIT_CNT-1:0];
            end else if (lane_sum[i] < SAT_MIN) begin
                lane_sat[i] = SAT_MIN[BIT_CNT-1:0];
            end else begin
                lane_sat[i] = lane_sum[i][BIT_CNT-1:0];
            end
        end
    end

    // Group sequencing. flush wins over a concurrent beat while collecting,
    // but a held result is never disturbed by it. On the last beat the
    // activation and saturated sum are captured so they are stable for the
    // whole time out_valid is high and keep their values after the drain.
    always_comb begin
        state_d  = state_q;
        ch_cnt_d = ch_cnt_q;
        act_d    = act_q;
        sum_d    = sum_q;
        for (int i = 0; i < OUTPUT_DIM; i++) begin
            acc_d[i] = acc_q[i];
        end

        unique case (state_q)
            IDLE, ACCUM: begin
                if (flush) begin
                    state_d  = IDLE;
                    ch_cnt_d = '0;
                end else if (accept) begin
                    for (int i = 0; i < OUTPUT_DIM; i++) begin
                        acc_d[i] = lane_sum[i];
                    end
                    if (last_beat) begin
                        state_d  = HOLD;
                        ch_cnt_d = FULL_CNT;
                        act_d    = lane_act;
                        sum_d    = lane_sat;
                    end else begin
                        state_d  = ACCUM;
                        ch_cnt_d = ch_cnt_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d  = IDLE;
                    ch_cnt_d = '0;
                end
            end
            default: begin
                state_d  = IDLE;
                ch_cnt_d = '0;
            end
        endcase
    end

    // State, counter, accumulators and result registers. Asynchronous reset
    // drops any partial group so the next accepted beat starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ch_cnt_q <= '0;
            act_q    <= '0;
            sum_q    <= '0;
            for (int i = 0; i < OUTPUT_DIM; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            ch_cnt_q <= ch_cnt_d;
            act_q    <= act_d;
            sum_q    <= sum_d;
            for (int i = 0; i < OUTPUT_DIM; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

endmodule

// File: tb/tb_bin_act_accum.sv
// -----------------------------------------------------------------------------
// tb_bin_act_accum
//
// Directed testbench for bin_act_accum (OUTPUT_DIM 16, BIT_CNT 8,
// CHANNEL_CNT 4). Expected results are pushed into a scoreboard queue when a
// group is issued; an independent monitor pops and compares each result when
// the accumulator presents it, and checks it stays stable while held.
// -----------------------------------------------------------------------------
module tb_bin_act_accum;

    localparam int OUTPUT_DIM  = 16;
    localparam int BIT_CNT     = 8;
    localparam int CHANNEL_CNT = 4;
    localparam int ACC_W       = 11;
    localparam int CNT_W       = 3;

    typedef struct packed {
        logic [OUTPUT_DIM-1:0]          act;
        logic [OUTPUT_DIM*BIT_CNT-1:0]  sum;
        logic [CNT_W-1:0]               cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic [CNT_W-1:0] ch_cnt;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    bin_act_accum_if #(
        .OUTPUT_DIM(OUTPUT_DIM),
        .BIT_CNT(BIT_CNT),
        .CHANNEL_CNT(CHANNEL_CNT)
    ) bus ();

    bin_act_accum #(
        .OUTPUT_DIM(OUTPUT_DIM),
        .BIT_CNT(BIT_CNT),
        .CHANNEL_CNT(CHANNEL_CNT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .ch_cnt(ch_cnt),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // One comparison: counts it and reports a mismatch with both values.
    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Sets every lane threshold to t_all, then overrides lane 0 with t0.
    task automatic setThreshold(input logic signed [ACC_W-1:0] t_all,
                                input logic signed [ACC_W-1:0] t0);
        for (int i = 0; i < OUTPUT_DIM; i++) bus.threshold[i] = t_all;
        bus.threshold[0] = t0;
    endtask

    // Drives one beat (lane 0 gets v0, the rest v_all) for one clock edge.
    // Entered and left 1 time unit after a rising edge.
    task automatic applyStimulus(input logic signed [BIT_CNT-1:0] v_all,
                                 input logic signed [BIT_CNT-1:0] v0,
                                 input logic do_flush);
        bus.in_valid = 1'b1;
        for (int i = 0; i < OUTPUT_DIM; i++) bus.value_in[i] = v_all;
        bus.value_in[0] = v0;
        flush = do_flush;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        flush = 1'b0;
    endtask

    // Four identical beats, with counter and one-cycle latency checks.
    task automatic runUniformGroup(input string tag, input logic signed [BIT_CNT-1:0] v,
                                   input logic [OUTPUT_DIM-1:0] exp_act,
                                   input logic [BIT_CNT-1:0] exp_sum);
        sb.push_back('{act: exp_act, sum: {OUTPUT_DIM{exp_sum}}, cnt: CNT_W'(4)});
        for (int b = 0; b < CHANNEL_CNT; b++) begin
            applyStimulus(v, v, 1'b0);
            if (b < CHANNEL_CNT - 1) begin
                checkOutput({tag, "_cnt"}, ch_cnt, b + 1);
                checkOutput({tag, "_early_valid"}, bus.out_valid, 1'b0);
            end
        end
        checkOutput({tag, "_latency"}, bus.out_valid, 1'b1);
        checkOutput({tag, "_hold_cnt"}, ch_cnt, 4);
    endtask

    // With out_ready high the held result drains on the next edge.
    task automatic drainResult(input string tag);
        @(posedge clk);
        #1;
        checkOutput({tag, "_drain_valid"}, bus.out_valid, 1'b0);
        checkOutput({tag, "_drain_ready"}, bus.in_ready, 1'b1);
        checkOutput({tag, "_drain_cnt"}, ch_cnt, 0);
    endtask

    // Scoreboard monitor: pops an expectation on each new result and checks
    // the result stays unchanged for as long as it is held.
    initial begin
        exp_t cur;
        logic seen;
        logic have_cur;
        seen = 1'b0;
        have_cur = 1'b0;
        cur = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 1'b0;
            end else begin
                if (bus.out_valid && !seen) begin
                    seen = 1'b1;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        have_cur = 1'b0;
                        $display("[TB] FAIL unexpected_result act=%0h sum=%0h", bus.act_out, bus.sum_out);
                    end else begin
                        cur = sb.pop_front();
                        have_cur = 1'b1;
                        checkOutput("sb_act", bus.act_out, cur.act);
                        checkOutput("sb_sum", bus.sum_out, cur.sum);
                        checkOutput("sb_cnt", ch_cnt, cur.cnt);
                    end
                end else if (bus.out_valid && have_cur) begin
                    checkOutput("hold_act", bus.act_out, cur.act);
                    checkOutput("hold_sum", bus.sum_out, cur.sum);
                end
                if (bus.out_valid && bus.out_ready) seen = 1'b0;
            end
        end
    end

    // Directed stimulus sequence.
    initial begin
        int pulses;
        int wait_cnt;

        rst_n = 1'b0;
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.value_in  = '0;
        bus.threshold = '0;
`ifdef BIN_ACT_INV_EN
        bus.thr_inv   = '0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_valid", bus.out_valid, 1'b0);
        checkOutput("rst_ready", bus.in_ready, 1'b1);
        checkOutput("rst_cnt", ch_cnt, 0);
        checkOutput("rst_act", bus.act_out, 0);
        checkOutput("rst_sum", bus.sum_out, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] test 1: positive saturation");
        setThreshold(11'sd0, 11'sd0);
        runUniformGroup("t1", 8'sd127, 16'hFFFF, 8'h7F);
        drainResult("t1");

        $display("[TB] test 2: negative saturation");
        runUniformGroup("t2", -8'sd128, 16'h0000, 8'h80);
        drainResult("t2");

        $display("[TB] test 3: threshold boundary on lane 0");
        sb.push_back('{act: 16'hFFFF, sum: '0, cnt: CNT_W'(4)});
        applyStimulus(8'sd0, 8'sd10, 1'b0);
        applyStimulus(8'sd0, -8'sd3, 1'b0);
        applyStimulus(8'sd0, 8'sd5, 1'b0);
        applyStimulus(8'sd0, -8'sd12, 1'b0);
        checkOutput("t3a_latency", bus.out_valid, 1'b1);
        drainResult("t3a");
        setThreshold(11'sd0, 11'sd1);
        sb.push_back('{act: 16'hFFFE, sum: '0, cnt: CNT_W'(4)});
        applyStimulus(8'sd0, 8'sd10, 1'b0);
        applyStimulus(8'sd0, -8'sd3, 1'b0);
        applyStimulus(8'sd0, 8'sd5, 1'b0);
        applyStimulus(8'sd0, -8'sd12, 1'b0);
        checkOutput("t3b_latency", bus.out_valid, 1'b1);
        drainResult("t3b");
        setThreshold(11'sd0, 11'sd0);

        $display("[TB] test 4: output backpressure");
        bus.out_ready = 1'b0;
        runUniformGroup("t4", 8'sd7, 16'hFFFF, 8'h1C);
        bus.in_valid = 1'b1;
        for (int i = 0; i < OUTPUT_DIM; i++) bus.value_in[i] = 8'sd100;
        for (int k = 0; k < 5; k++) begin
            checkOutput("t4_stall_valid", bus.out_valid, 1'b1);
            checkOutput("t4_stall_ready", bus.in_ready, 1'b0);
            checkOutput("t4_stall_cnt", ch_cnt, 4);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checkOutput("t4_after_valid", bus.out_valid, 1'b0);
        checkOutput("t4_after_ready", bus.in_ready, 1'b1);
        checkOutput("t4_after_cnt", ch_cnt, 0);
        runUniformGroup("t4b", 8'sd3, 16'hFFFF, 8'h0C);
        drainResult("t4b");

        $display("[TB] test 5: flush with concurrent beat");
        applyStimulus(8'sd50, 8'sd50, 1'b0);
        applyStimulus(8'sd50, 8'sd50, 1'b0);
        checkOutput("t5_pre_cnt", ch_cnt, 2);
        applyStimulus(8'sd50, 8'sd50, 1'b1);
        checkOutput("t5_flush_cnt", ch_cnt, 0);
        checkOutput("t5_flush_valid", bus.out_valid, 1'b0);
        runUniformGroup("t5", 8'sd1, 16'hFFFF, 8'h04);
        drainResult("t5");

        $display("[TB] test 6: reset mid-group");
        applyStimulus(8'sd20, 8'sd20, 1'b0);
        applyStimulus(8'sd20, 8'sd20, 1'b0);
        applyStimulus(8'sd20, 8'sd20, 1'b0);
        checkOutput("t6_pre_cnt", ch_cnt, 3);
        #3;
        rst_n = 1'b0;
        #2;
        checkOutput("t6_rst_valid", bus.out_valid, 1'b0);
        checkOutput("t6_rst_cnt", ch_cnt, 0);
        checkOutput("t6_rst_act", bus.act_out, 0);
        checkOutput("t6_rst_sum", bus.sum_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        runUniformGroup("t6", 8'sd2, 16'hFFFF, 8'h08);
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus.out_valid) pulses++;
            @(posedge clk);
            #1;
        end
        checkOutput("t6_pulses", pulses, 1);

        wait_cnt = 0;
        while (sb.size() != 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        checkOutput("sb_pending", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin_act_accum.md
Name: bin_act_accum

Overview:
- Sits directly downstream of the fixed-input/binary-weight dot-product stage.
- Accepts one OUTPUT_DIM-wide vector of signed partial sums per beat and accumulates CHANNEL_CNT beats, one per input channel group.
- Compares each accumulated sum against a folded-batchnorm threshold and emits a binary activation vector for the next binary layer, plus a saturated fixed-point sum.
- Valid/ready handshakes on both sides.

Parameters:
- OUTPUT_DIM, 16, lanes per beat (matches upstream output vector).
- BIT_CNT, 8, signed two's-complement width of each input lane and of sum_out.
- CHANNEL_CNT, 4, beats accumulated per result; must be >= 1.
- ACC_W, BIT_CNT+$clog2(CHANNEL_CNT)+1, accumulator and threshold width (derived; do not override).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  value_in beat valid.
- in_ready  out  1  block accepts a beat.
- value_in  in  [OUTPUT_DIM][BIT_CNT]  signed partial sums from the upstream stage.
- flush  in  1  synchronous discard of the partial accumulation.
- threshold  in  [OUTPUT_DIM][ACC_W]  signed per-lane threshold; sampled on the final beat.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- act_out  out  [OUTPUT_DIM]  1 = +1 activation, 0 = -1.
- sum_out  out  [OUTPUT_DIM][BIT_CNT]  accumulated sum saturated to BIT_CNT.
- ch_cnt  out  $clog2(CHANNEL_CNT)+1  beats accepted in the current group.

Behaviour:
- Reset: one clock, asynchronous and active-low.
  - Async assert clears out_valid=0, act_out=0, sum_out=0, ch_cnt=0, all accumulators=0, state=IDLE.
  - Release is synchronous to clk.
- Handshake:
  - in_ready = !out_valid (combinational).
  - A beat is accepted when in_valid && in_ready.
  - The result transfers when out_valid && out_ready.
  - No input beat is accepted in the same cycle the result drains; the next beat is accepted at the earliest in the following cycle.
- FSM:
  - IDLE (ch_cnt=0, out_valid=0) -> ACCUM on an accepted beat when CHANNEL_CNT>1.
  - IDLE -> HOLD directly when CHANNEL_CNT=1.
  - ACCUM -> HOLD on the accepted beat that makes ch_cnt reach CHANNEL_CNT.
  - HOLD (out_valid=1) -> IDLE on the output handshake.
- Accumulation:
  - acc[i] <= (ch_cnt==0 ? sext(value_in[i]) : acc[i]+sext(value_in[i])).
  - ACC_W has one guard bit beyond the worst case, so there is no internal overflow: -128*4=-512 and 127*4=508 both fit in 11 bits.
- Final beat (combinational on the last accepted beat, registered into HOLD):
  - final = acc + sext(value_in).
  - act_out[i] = (final >= threshold[i]), signed compare.
  - sum_out[i] = final clamped to [-2^(BIT_CNT-1), 2^(BIT_CNT-1)-1].
- Latency: out_valid rises exactly 1 cycle after the last beat is accepted.
- Output stability: act_out and sum_out hold until the handshake, and keep their last values afterwards.
- flush:
  - Sets ch_cnt=0; the state returns to IDLE if it was in ACCUM.
  - Has priority over a beat accepted in the same cycle; that beat is dropped.
  - No effect in HOLD: a pending result is never lost.
- ch_cnt:
  - Increments per accepted beat.
  - Reads CHANNEL_CNT while in HOLD.
  - Returns to 0 on the handshake.
- Reset mid-group: the partial sum is lost and the next beat starts a fresh group.

Optional Feature:
- Macro: BIN_ACT_INV_EN.
- When defined:
  - Adds input thr_inv [OUTPUT_DIM] for negative batchnorm gamma.
  - Lanes with thr_inv[i]=1 use act_out[i] = (final <= threshold[i]).
  - thr_inv is sampled on the final beat, like threshold.
- When undefined:
  - The port is absent.
  - All lanes use >=.

Test Plan:
1. All lanes 127 for 4 beats, threshold=0 -> out_valid 1 cycle after 4th beat; sum_out=127 (saturated from 508); act_out=16'hFFFF; ch_cnt=4.
2. All lanes -128 for 4 beats, threshold=0 -> sum_out=-128 (8'h80); act_out=16'h0000.
3. Lane 0 beats 10,-3,5,-12 -> final 0:
   - threshold[0]=0 gives act_out[0]=1, sum_out[0]=0.
   - Repeat with threshold[0]=1 gives act_out[0]=0.
4. out_ready=0 for 5 cycles after a result -> out_valid stays 1, in_ready=0, outputs stable.
   - Raise out_ready -> handshake, in_ready=1 next cycle; next group accumulates from zero.
5. 2 beats of 50, then flush with a concurrent beat, then 4 beats of 1 -> result sum_out=4 (flushed and concurrent beats discarded).
6. rst_n low mid-cycle after 3 beats of 20 -> outputs cleared immediately; then 4 beats of 2 -> sum_out=8, out_valid pulses once.
